// File: rtl/result_viewer_pkg.sv
// rtl/result_viewer_pkg.sv - shared types, width helper and default parameters for result_viewer
package result_viewer_pkg;

  typedef enum logic {IDLE, SHOW} state_t;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_OUT_W        = 16;
  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_AUTO_PERIOD  = 0;

  // Bits needed to index n items, never less than one.
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, stable-level debounce and rising-edge press pulse
module btn_debounce
  import result_viewer_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);

  localparam int CW = clog2w(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          btn_state;
  logic          btn_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      btn_state <= 1'b0;
      btn_prev  <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1    <= button;
      sync2    <= sync1;
      btn_prev <= btn_state;
      if (sync2 == btn_state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This cycle is the DEBOUNCE_CYC-th consecutive differing one.
        btn_state <= sync2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = btn_state & ~btn_prev;

endmodule

// File: rtl/result_viewer.sv
// rtl/result_viewer.sv - captures NUM_CH result words and steps an OUT_W-bit window through them
module result_viewer
  import result_viewer_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int OUT_W        = DEF_OUT_W,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int AUTO_PERIOD  = DEF_AUTO_PERIOD
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   button,
  input  logic                                   cap_en,
  input  logic [NUM_CH*DATA_W-1:0]               data_in,
  output logic [OUT_W-1:0]                       out,
  output logic [clog2w(NUM_CH)-1:0]              ch_idx,
  output logic [clog2w(DATA_W / OUT_W)-1:0]      slice_idx,
  output logic                                   captured
);

  localparam int SLICES = DATA_W / OUT_W;
  localparam int CH_W   = clog2w(NUM_CH);
  localparam int SL_W   = clog2w(SLICES);
  localparam int AW     = clog2w(AUTO_PERIOD + 1);
  localparam bit AUTO_EN = (AUTO_PERIOD > 0);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [SL_W-1:0] SL_LAST = SL_W'(SLICES - 1);
  localparam logic [AW-1:0]   AP_LAST = AW'(AUTO_EN ? AUTO_PERIOD - 1 : 0);

  state_t                    state;
  logic [NUM_CH*DATA_W-1:0]  snapshot;
  logic [AW-1:0]             auto_cnt;
  logic                      press;
  logic                      auto_tick;
  logic                      step;
  logic [CH_W-1:0]           nxt_ch;
  logic [SL_W-1:0]           nxt_sl;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .press  (press)
  );

  function automatic logic [OUT_W-1:0] pick(input logic [NUM_CH*DATA_W-1:0] s,
                                            input int c, input int l);
    return s[(c * SLICES + l) * OUT_W +: OUT_W];
  endfunction

  assign auto_tick = AUTO_EN && (auto_cnt == AP_LAST);
  assign step      = press | auto_tick;

  always_comb begin
    nxt_sl = (slice_idx == SL_LAST) ? '0 : slice_idx + 1'b1;
    nxt_ch = ch_idx;
    if (slice_idx == SL_LAST) nxt_ch = (ch_idx == CH_LAST) ? '0 : ch_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      snapshot  <= '0;
      out       <= '0;
      ch_idx    <= '0;
      slice_idx <= '0;
      captured  <= 1'b0;
      auto_cnt  <= '0;
    end else if (cap_en) begin
      // Capture wins over any step arriving in the same cycle.
      state     <= SHOW;
      snapshot  <= data_in;
      out       <= data_in[OUT_W-1:0];
      ch_idx    <= '0;
      slice_idx <= '0;
      captured  <= 1'b1;
      auto_cnt  <= '0;
    end else begin
      case (state)
        SHOW: begin
          if (step) begin
            ch_idx    <= nxt_ch;
            slice_idx <= nxt_sl;
            out       <= pick(snapshot, int'(nxt_ch), int'(nxt_sl));
          end
          if (step || !AUTO_EN) auto_cnt <= '0;
          else                  auto_cnt <= auto_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_viewer.sv
// tb/tb_result_viewer.sv - vector table, hand sequences and random model check of result_viewer
module tb_result_viewer;

  localparam int DATA_W = 32;
  localparam int OUT_W  = 16;
  localparam int NUM_CH = 2;
  localparam int SLICES = DATA_W / OUT_W;

  localparam int OP_PRESS  = 0;
  localparam int OP_GLITCH = 1;
  localparam int OP_CAP    = 2;
  localparam int OP_NOISE  = 3;

  typedef struct {
    int          op;
    int          arg;
    logic [63:0] data;
    logic [15:0] exp_out;
    int          exp_ch;
    int          exp_sl;
    logic        exp_cap;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        button;
  logic        cap_en;
  logic [63:0] data_in;
  logic [15:0] d_out, a_out;
  logic        d_ch, d_sl, d_cap, a_ch, a_sl, a_cap;

  int checks = 0;
  int errors = 0;

  vec_t vec [11];

  logic [31:0] m_snap [NUM_CH];
  logic        m_cap;
  int          m_pos;

  always #5 clk = ~clk;

  result_viewer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .DEBOUNCE_CYC(4),
                  .AUTO_PERIOD(0)) u_dut (
    .clk(clk), .rst(rst), .button(button), .cap_en(cap_en), .data_in(data_in),
    .out(d_out), .ch_idx(d_ch), .slice_idx(d_sl), .captured(d_cap)
  );

  result_viewer #(.DATA_W(DATA_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .DEBOUNCE_CYC(4),
                  .AUTO_PERIOD(8)) u_auto (
    .clk(clk), .rst(rst), .button(button), .cap_en(cap_en), .data_in(data_in),
    .out(a_out), .ch_idx(a_ch), .slice_idx(a_sl), .captured(a_cap)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_d(input string name, input logic [15:0] o, input int c, input int s,
                         input logic cp);
    check({name, ".out"}, 32'(d_out), 32'(o));
    check({name, ".ch"}, 32'(d_ch), 32'(c));
    check({name, ".slice"}, 32'(d_sl), 32'(s));
    check({name, ".captured"}, 32'(d_cap), 32'(cp));
  endtask

  task automatic do_press(input int hold);
    button = 1'b1;
    repeat (hold) @(negedge clk);
    button = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_glitch(input int len);
    button = 1'b1;
    repeat (len) @(negedge clk);
    button = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_cap(input logic [63:0] d);
    data_in = d;
    cap_en  = 1'b1;
    @(negedge clk);
    cap_en  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [15:0] model_out();
    logic [31:0] w;
    if (!m_cap) return 16'h0;
    w = m_snap[m_pos / SLICES];
    return 16'(w >> (OUT_W * (m_pos % SLICES)));
  endfunction

  function automatic int auto_pos(input int t);
    if (t < 8)  return 0;
    if (t < 13) return 1;
    if (t < 21) return 2;
    return 3;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] auto_seq [4];
    rst     = 1'b0;
    button  = 1'b0;
    cap_en  = 1'b0;
    data_in = {32'h12345678, 32'hDEADBEEF};

    vec[0]  = '{OP_PRESS,  8, 64'h12345678_DEADBEEF, 16'h0000, 0, 0, 1'b0};
    vec[1]  = '{OP_CAP,    0, 64'h12345678_DEADBEEF, 16'hBEEF, 0, 0, 1'b1};
    vec[2]  = '{OP_PRESS,  8, 64'h0,                 16'hDEAD, 0, 1, 1'b1};
    vec[3]  = '{OP_PRESS,  8, 64'h0,                 16'h5678, 1, 0, 1'b1};
    vec[4]  = '{OP_PRESS,  8, 64'h0,                 16'h1234, 1, 1, 1'b1};
    vec[5]  = '{OP_PRESS,  8, 64'h0,                 16'hBEEF, 0, 0, 1'b1};
    vec[6]  = '{OP_GLITCH, 3, 64'h0,                 16'hBEEF, 0, 0, 1'b1};
    vec[7]  = '{OP_GLITCH, 1, 64'h0,                 16'hBEEF, 0, 0, 1'b1};
    vec[8]  = '{OP_NOISE,  0, 64'h00000000_AAAA5555, 16'hBEEF, 0, 0, 1'b1};
    vec[9]  = '{OP_GLITCH, 4, 64'h0,                 16'hDEAD, 0, 1, 1'b1};
    vec[10] = '{OP_PRESS,  5, 64'h0,                 16'h5678, 1, 0, 1'b1};

    repeat (2) @(negedge clk);
    check_d("reset", 16'h0, 0, 0, 1'b0);
    check("reset.auto_out", 32'(a_out), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      case (vec[i].op)
        OP_PRESS:  do_press(vec[i].arg);
        OP_GLITCH: do_glitch(vec[i].arg);
        OP_CAP:    do_cap(vec[i].data);
        default: begin
          data_in = vec[i].data;
          repeat (3) @(negedge clk);
        end
      endcase
      check_d($sformatf("vec%0d", i), vec[i].exp_out, vec[i].exp_ch, vec[i].exp_sl,
              vec[i].exp_cap);
    end

    // Exact press latency: advance lands on sampling edge 6, not 5.
    button = 1'b1;
    repeat (6) @(negedge clk);
    check_d("latency.edge5", 16'h5678, 1, 0, 1'b1);
    @(negedge clk);
    check_d("latency.edge6", 16'h1234, 1, 1, 1'b1);
    button = 1'b0;
    repeat (10) @(negedge clk);

    // Capture coincident with the press pulse drops the step.
    data_in = {32'h12345678, 32'hCAFEF00D};
    button  = 1'b1;
    repeat (6) @(negedge clk);
    cap_en = 1'b1;
    @(negedge clk);
    cap_en = 1'b0;
    check_d("collide", 16'hF00D, 0, 0, 1'b1);
    button = 1'b0;
    repeat (10) @(negedge clk);
    check_d("collide.after", 16'hF00D, 0, 0, 1'b1);
    do_press(8);
    check_d("collide.p1", 16'hCAFE, 0, 1, 1'b1);
    do_press(8);
    check_d("collide.p2", 16'h5678, 1, 0, 1'b1);

    // Asynchronous reset between edges while showing.
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_d("async_rst", 16'h0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_d("post_rst", 16'h0, 0, 0, 1'b0);
    do_press(8);
    check_d("post_rst.press", 16'h0, 0, 0, 1'b0);

    // Auto mode on the AUTO_PERIOD=8 instance, with a manual press 5 cycles after the first tick.
    auto_seq[0] = 16'hBEEF;
    auto_seq[1] = 16'hDEAD;
    auto_seq[2] = 16'h5678;
    auto_seq[3] = 16'h1234;
    do_cap({32'h12345678, 32'hDEADBEEF});
    check("auto.t0", 32'(a_out), 32'hBEEF);
    for (int t = 1; t <= 22; t++) begin
      @(negedge clk);
      check($sformatf("auto.t%0d", t), 32'(a_out), 32'(auto_seq[auto_pos(t)]));
      if (t == 6)  button = 1'b1;
      if (t == 14) button = 1'b0;
    end
    repeat (10) @(negedge clk);

    // Random operations against a word/position model.
    do_reset();
    m_cap = 1'b0;
    m_pos = 0;
    for (int c = 0; c < NUM_CH; c++) m_snap[c] = '0;
    for (int n = 0; n < 40; n++) begin
      int op;
      logic [63:0] d;
      op = $urandom_range(0, 4);
      d  = {$urandom(), $urandom()};
      case (op)
        0: begin
          do_cap(d);
          m_cap = 1'b1;
          m_pos = 0;
          for (int c = 0; c < NUM_CH; c++) m_snap[c] = d[c*DATA_W +: DATA_W];
        end
        1, 2: begin
          do_press($urandom_range(4, 8));
          if (m_cap) m_pos = (m_pos + 1) % (NUM_CH * SLICES);
        end
        3: do_glitch($urandom_range(1, 3));
        default: begin
          data_in = d;
          repeat (3) @(negedge clk);
        end
      endcase
      check_d($sformatf("rand%0d", n), model_out(), m_pos / SLICES, m_pos % SLICES, m_cap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
